// File: rtl/h_pc_stack.sv
// Program counter with a DEPTH-entry return-address stack and sticky overflow/underflow flags.
// Optional macro H_PC_STACK_CIRC_EN: a call while full overwrites the oldest entry instead of being dropped.
module h_pc_stack #(
  parameter int                 WIDTH      = 16,
  parameter int                 DEPTH      = 8,
  parameter logic [WIDTH-1:0]   RESET_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     load,
  input  logic                     inc,
  input  logic                     call,
  input  logic                     ret,
  input  logic [WIDTH-1:0]         in,
  output logic [WIDTH-1:0]         out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] stack [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] ret_addr;
  logic             push_en;

  assign ret_addr = out + WIDTH'(1);
  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));

`ifdef H_PC_STACK_CIRC_EN
  logic [AW-1:0] base;

  // When full, base+level wraps onto base itself, i.e. the oldest entry.
  assign wr_idx  = base + level[AW-1:0];
  assign rd_idx  = wr_idx - AW'(1);
  assign push_en = !clr && !ret && call;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      base <= '0;
    else if (clr)
      base <= '0;
    else if (!ret && call && full)
      base <= base + AW'(1);
  end
`else
  // Low bits of level still address the top correctly when level==DEPTH.
  assign wr_idx  = level[AW-1:0];
  assign rd_idx  = wr_idx - AW'(1);
  assign push_en = !clr && !ret && call && !full;
`endif

  // Stack contents need no reset; level alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push_en)
      stack[wr_idx] <= ret_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= RESET_ADDR;
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (clr) begin
      out   <= RESET_ADDR;
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (ret) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        out   <= stack[rd_idx];
        level <= level - LW'(1);
      end
    end else if (call) begin
      out <= in;
      if (full)
        ovf <= 1'b1;
      else
        level <= level + LW'(1);
    end else if (load) begin
      out <= in;
    end else if (inc) begin
      out <= ret_addr;
    end
  end

endmodule

// File: tb/tb_h_pc_stack.sv
// Randomised scoreboard bench for h_pc_stack against a queue-based reference model.
module tb_h_pc_stack;

  localparam int               WIDTH = 16;
  localparam int               DEPTH = 8;
  localparam logic [WIDTH-1:0] RST   = 16'h0000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 0, load = 0, inc = 0, call = 0, ret = 0;
  logic [WIDTH-1:0] in = '0;
  logic [WIDTH-1:0] out;
  logic [3:0]       level;
  logic             empty, full, ovf, unf;

  h_pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_ADDR(RST)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .inc(inc), .call(call),
    .ret(ret), .in(in), .out(out), .level(level), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] pc;
    int               lvl;
    bit               ovf;
    bit               unf;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] m_pc;
  logic [WIDTH-1:0] m_stk[$];
  bit               m_ovf, m_unf;
  int               n_tests = 0;
  int               n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  // One clock of stimulus; the model advances and its expectation is queued.
  task automatic step(input bit c_clr, input bit c_ret, input bit c_call,
                      input bit c_load, input bit c_inc, input logic [WIDTH-1:0] c_in);
    exp_t e;
    @(negedge clk);
    clr = c_clr; ret = c_ret; call = c_call; load = c_load; inc = c_inc; in = c_in;
    if (c_clr) begin
      model_reset();
    end else if (c_ret) begin
      if (m_stk.size() == 0) m_unf = 1;
      else m_pc = m_stk.pop_back();
    end else if (c_call) begin
      if (m_stk.size() < DEPTH) begin
        m_stk.push_back(m_pc + 16'd1);
      end else begin
        m_ovf = 1;
`ifdef H_PC_STACK_CIRC_EN
        void'(m_stk.pop_front());
        m_stk.push_back(m_pc + 16'd1);
`endif
      end
      m_pc = c_in;
    end else if (c_load) begin
      m_pc = c_in;
    end else if (c_inc) begin
      m_pc = m_pc + 16'd1;
    end
    e.pc = m_pc; e.lvl = m_stk.size(); e.ovf = m_ovf; e.unf = m_unf;
    sb.push_back(e);
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, '0); endtask

  // Monitor: the DUT presents a new state every clock; compare it to the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      chk("out",   {16'd0, out},         {16'd0, e.pc});
      chk("level", {28'd0, level},       e.lvl);
      chk("empty", {31'd0, empty},       {31'd0, e.lvl == 0});
      chk("full",  {31'd0, full},        {31'd0, e.lvl == DEPTH});
      chk("ovf",   {31'd0, ovf},         {31'd0, e.ovf});
      chk("unf",   {31'd0, unf},         {31'd0, e.unf});
    end
  end

  initial begin
    model_reset();
    #2;
    chk("rst_out",   {16'd0, out},   {16'd0, RST});
    chk("rst_level", {28'd0, level}, 0);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_flags", {30'd0, ovf, unf}, 0);
    @(negedge clk); rst_n = 1;

    // Reset and inc
    repeat (3) step(0, 0, 0, 0, 1, '0);
    // Wrap
    step(0, 0, 0, 1, 0, 16'hFFFF);
    step(0, 0, 0, 0, 1, '0);
    // Nested call/ret from 0x0010
    step(0, 0, 0, 1, 0, 16'h0010);
    step(0, 0, 1, 0, 0, 16'h0100);
    step(0, 0, 1, 0, 0, 16'h0200);
    step(0, 1, 0, 0, 0, '0);
    step(0, 1, 0, 0, 0, '0);
    // Overflow: 9 calls from 0, 9 rets
    step(1, 0, 0, 0, 0, '0);
    for (int k = 0; k < 9; k++) step(0, 0, 1, 0, 0, 16'h1000 + 16'(k));
    idle(); @(posedge clk); #2;
    chk("ovf_out",   {16'd0, out},   {16'd0, 16'h1008});
    chk("ovf_level", {28'd0, level}, DEPTH);
    chk("ovf_flag",  {31'd0, ovf},   1);
    for (int k = 0; k < 9; k++) step(0, 1, 0, 0, 0, '0);
    idle(); @(posedge clk); #2;
`ifndef H_PC_STACK_CIRC_EN
    chk("unf_out", {16'd0, out}, {16'd0, 16'h0001});
`endif
    chk("unf_flag", {31'd0, unf}, 1);
    // Priority and clr
    step(0, 0, 1, 1, 1, 16'h0040);
    step(1, 1, 0, 0, 0, '0);
    // Async reset with level=3, out=0x0300
    step(0, 0, 1, 0, 0, 16'h0100);
    step(0, 0, 1, 0, 0, 16'h0200);
    step(0, 0, 1, 0, 0, 16'h0300);
    idle();
    @(posedge clk); #3;
    chk("pre_arst_level", {28'd0, level}, 3);
    rst_n = 0;
    #1;
    chk("arst_out",   {16'd0, out},   {16'd0, RST});
    chk("arst_level", {28'd0, level}, 0);
    @(negedge clk); rst_n = 1; model_reset();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [WIDTH-1:0] r_in;
      r_in = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 0, r_in);
    end
    idle();
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
